// File: rtl/spectro_pkg.sv
// rtl/spectro_pkg.sv - shared constants and types for the spectrogram counter path
package spectro_pkg;

  localparam bit SAT_MODE_SAT  = 1'b1;
  localparam bit SAT_MODE_WRAP = 1'b0;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/impulse_sync_edge.sv
// rtl/impulse_sync_edge.sv - multi-flop synchronizer with rising-edge pulse for one impulse line
module impulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational pulse so the counter sees the event one clk after the last sync stage.
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/channel_counter_bank.sv
// rtl/channel_counter_bank.sv - per-channel impulse counters with framed snapshot and streamed readout
module channel_counter_bank
  import spectro_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int CNT_W       = 12,
  parameter int FRAME_LEN   = 1024,
  parameter bit SAT_MODE    = SAT_MODE_SAT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_CH-1:0]           impulse,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ch_idx_w(N_CH)-1:0] out_ch,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_ovf,
  output logic                      frame_done,
  output logic                      frame_overrun
);

  localparam int               IW       = ch_idx_w(N_CH);
  localparam int               TW       = $clog2(FRAME_LEN);
  localparam logic [TW-1:0]    T_LAST   = TW'(FRAME_LEN - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N_CH-1:0]  ev;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] shadow_cnt_q [N_CH];
  logic [N_CH-1:0]  ovf_q, ovf_d, shadow_ovf_q;
  logic [TW-1:0]    timer_q;
  rd_state_e        state_q;
  logic [IW-1:0]    idx_q;
  logic             frame_done_q, overrun_q;
  logic             snap;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    impulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (impulse[g]),
      .pulse_o (ev[g])
    );
  end

  assign snap = enable && (timer_q == T_LAST);

  // On the snapshot cycle the live counter restarts, so a coincident event opens the new frame.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = ovf_q[c];
      if (snap) begin
        cnt_d[c] = CNT_W'(ev[c]);
        ovf_d[c] = 1'b0;
      end else if (enable && ev[c]) begin
        if (cnt_q[c] != CNT_MAX) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end else begin
          ovf_d[c] = 1'b1;
          if (SAT_MODE == SAT_MODE_WRAP) cnt_d[c] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
      ovf_q <= ovf_d;
    end
  end

  // A snapshot arriving while any word is still pending (even the last one) is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q      <= '0;
      state_q      <= RD_IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      shadow_ovf_q <= '0;
      for (int c = 0; c < N_CH; c++) shadow_cnt_q[c] <= '0;
    end else begin
      frame_done_q <= snap;
      if (enable) timer_q <= (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
      if (state_q == RD_SEND && out_ready) begin
        if (idx_q == IDX_LAST) begin
          state_q <= RD_IDLE;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
      if (snap) begin
        if (state_q == RD_IDLE) begin
          state_q      <= RD_SEND;
          idx_q        <= '0;
          shadow_ovf_q <= ovf_q;
          for (int c = 0; c < N_CH; c++) shadow_cnt_q[c] <= cnt_q[c];
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid     = (state_q == RD_SEND);
  assign out_ch        = idx_q;
  assign out_count     = shadow_cnt_q[idx_q];
  assign out_ovf       = shadow_ovf_q[idx_q];
  assign frame_done    = frame_done_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_channel_counter_bank.sv
// tb/tb_channel_counter_bank.sv - scoreboard bench for channel_counter_bank in saturate and wrap modes
module tb_channel_counter_bank;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int FL = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          out_ready = 1'b1;
  logic [N-1:0]  impulse = '0;

  logic          s_valid, s_ovf, s_fd, s_ovr;
  logic [1:0]    s_ch;
  logic [CW-1:0] s_cnt;
  logic          w_valid, w_ovf, w_fd, w_ovr;
  logic [1:0]    w_ch;
  logic [CW-1:0] w_cnt;

  always #5 clk = ~clk;

  channel_counter_bank #(.N_CH(N), .CNT_W(CW), .FRAME_LEN(FL), .SAT_MODE(1'b1), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .impulse(impulse),
    .out_valid(s_valid), .out_ready(out_ready), .out_ch(s_ch), .out_count(s_cnt),
    .out_ovf(s_ovf), .frame_done(s_fd), .frame_overrun(s_ovr)
  );

  channel_counter_bank #(.N_CH(N), .CNT_W(CW), .FRAME_LEN(FL), .SAT_MODE(1'b0), .SYNC_STAGES(2)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .impulse(impulse),
    .out_valid(w_valid), .out_ready(out_ready), .out_ch(w_ch), .out_count(w_cnt),
    .out_ovf(w_ovf), .frame_done(w_fd), .frame_overrun(w_ovr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {int ch; int cs; int os; int cw; int ow;} word_t;
  word_t q[$];
  int    ms[N], mw[N];
  bit    mos[N], mow[N];
  bit    h1[N], h2[N], h3[N], ev[N];
  int    mt;
  bit    m_fd, m_ovr, busy;

  // Event at an edge means the line was sampled high two edges earlier and low three edges earlier.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mt = 0; m_fd = 0; m_ovr = 0;
      for (int c = 0; c < N; c++) begin
        ms[c] = 0; mw[c] = 0; mos[c] = 0; mow[c] = 0;
        h1[c] = 0; h2[c] = 0; h3[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        ev[c] = h2[c] && !h3[c];
        h3[c] = h2[c]; h2[c] = h1[c]; h1[c] = impulse[c];
      end
      busy = (q.size() > 0);
      if (busy && out_ready) q.delete(0);
      m_fd = 0;
      if (enable) begin
        if (mt == FL - 1) begin
          m_fd = 1; mt = 0;
          if (busy) m_ovr = 1;
          else for (int c = 0; c < N; c++) q.push_back('{c, ms[c], mos[c], mw[c], mow[c]});
          for (int c = 0; c < N; c++) begin
            ms[c] = ev[c]; mw[c] = ev[c]; mos[c] = 0; mow[c] = 0;
          end
        end else begin
          mt++;
          for (int c = 0; c < N; c++) if (ev[c]) begin
            if (ms[c] < 15) ms[c]++; else mos[c] = 1;
            if (mw[c] < 15) mw[c]++; else begin mw[c] = 0; mow[c] = 1; end
          end
        end
      end
    end
  end

  bit chk_on = 0;
  int got_s[N], got_w[N], got_os[N], got_ow[N];

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("valid_sat", s_valid, q.size() > 0);
      check("valid_wrap", w_valid, q.size() > 0);
      check("fd_sat", s_fd, m_fd);
      check("fd_wrap", w_fd, m_fd);
      check("ovr_sat", s_ovr, m_ovr);
      check("ovr_wrap", w_ovr, m_ovr);
      if (q.size() > 0 && s_valid) begin
        check("ch_sat", s_ch, q[0].ch);
        check("cnt_sat", s_cnt, q[0].cs);
        check("ovf_sat", s_ovf, q[0].os);
        check("ch_wrap", w_ch, q[0].ch);
        check("cnt_wrap", w_cnt, q[0].cw);
        check("ovf_wrap", w_ovf, q[0].ow);
      end
      if (s_valid && out_ready) begin
        got_s[s_ch] = s_cnt; got_os[s_ch] = s_ovf;
        got_w[w_ch] = w_cnt; got_ow[w_ch] = w_ovf;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_fd && n < 400);
    if (!s_fd) check("fd_timeout", 0, 1);
  endtask

  task automatic pulse(input int c, input int n);
    repeat (n) begin
      impulse[c] = 1'b1; tick(); tick();
      impulse[c] = 1'b0; tick(); tick();
    end
  endtask

  int n, n6;

  initial begin
    repeat (3) tick();
    check("rst_valid", s_valid, 0);
    check("rst_ch", s_ch, 0);
    check("rst_cnt", s_cnt, 0);
    check("rst_ovf", s_ovf, 0);
    check("rst_fd", s_fd, 0);
    check("rst_ovr", s_ovr, 0);
    enable = 1'b1;
    reset  = 1'b0;
    chk_on = 1;

    wait_fd(n);
    check("t1_first_frame_len", n, 64);

    fork
      pulse(0, 5);
      pulse(2, 9);
    join
    wait_fd(n);

    fork
      pulse(1, 16);
      begin
        repeat (5) tick();
        check("t2_ch0", got_s[0], 5);
        check("t2_ch1", got_s[1], 0);
        check("t2_ch2", got_s[2], 9);
        check("t2_ch3", got_s[3], 0);
      end
    join
    check("t3_align", s_fd, 1);

    fork
      begin
        repeat (61) tick();
        impulse[3] = 1'b1; tick(); tick();
        impulse[3] = 1'b0;
      end
      begin
        repeat (5) tick();
        check("t3_sat_cnt", got_s[1], 15);
        check("t3_sat_ovf", got_os[1], 1);
        check("t3_wrap_cnt", got_w[1], 0);
        check("t3_wrap_ovf", got_ow[1], 1);
      end
    join
    wait_fd(n);
    check("t4_snap_gap", n, 1);
    repeat (5) tick();
    check("t4_snap_excl", got_s[3], 0);
    wait_fd(n);
    repeat (5) tick();
    check("t4_next_incl", got_s[3], 1);

    out_ready = 1'b0;
    pulse(2, 3);
    wait_fd(n);
    tick();
    check("t5_hold_valid", s_valid, 1);
    check("t5_hold_ch", s_ch, 0);
    pulse(0, 2);
    wait_fd(n);
    check("t5_overrun", s_ovr, 1);
    check("t5_frozen_ch", s_ch, 0);
    check("t5_frozen_cnt", s_cnt, 0);
    out_ready = 1'b1;
    repeat (5) tick();
    check("t5_ch2_kept", got_s[2], 3);
    check("t5_ch0_kept", got_s[0], 0);

    wait_fd(n);
    fork
      wait_fd(n6);
      begin
        repeat (10) tick();
        enable = 1'b0;
        pulse(0, 4);
        repeat (4) tick();
        enable = 1'b1;
      end
    join
    check("t6_frame_delay", n6, 84);
    repeat (5) tick();
    check("t6_ch0_dropped", got_s[0], 0);

    wait_fd(n);
    tick();
    check("t6_mid_valid", s_valid, 1);
    check("t6_mid_ch", s_ch, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", s_valid, 0);
    check("t6_rst_ch", s_ch, 0);
    check("t6_rst_cnt", s_cnt, 0);
    check("t6_rst_ovf", s_ovf, 0);
    check("t6_rst_fd", s_fd, 0);
    check("t6_rst_ovr", s_ovr, 0);
    check("t6_rst_wvalid", w_valid, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t6_post_valid", s_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
